// File: rtl/sprite_compositor.sv
// Per-pixel sprite compositor: one sprite-ROM read port is shared by NUM_SLOTS objects.
// Slots are scanned one per cycle in priority order; the first opaque hit wins over the background.
module sprite_compositor #(
  parameter int          NUM_SLOTS = 8,
  parameter int          SPR_W     = 20,
  parameter int          SPR_H     = 20,
  parameter int          SCR_W     = 320,
  parameter int          SCR_H     = 240,
  parameter logic [17:0] TRANSP    = 18'h00001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [9:0]  req_x,
  input  logic [9:0]  req_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [17:0] out_pixel,
  output logic [9:0]  bg_x,
  output logic [9:0]  bg_y,
  input  logic [17:0] bg_data,
  output logic        rd_en,
  output logic [3:0]  rd_sel,
  output logic [9:0]  rd_x,
  output logic [9:0]  rd_y,
  output logic [1:0]  rd_dir,
  input  logic [17:0] rd_data,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_slot,
  input  logic        cfg_en,
  input  logic [3:0]  cfg_sel,
  input  logic [1:0]  cfg_dir,
  input  logic [9:0]  cfg_x,
  input  logic [9:0]  cfg_y
);

  // state | meaning
  // IDLE  | waiting for a pixel request, req_ready high
  // SCAN  | evaluating slot k, issuing a ROM read on a hit
  // FLUSH | absorbing the read return of the last slot
  // DONE  | holding the composed pixel until out_ready

  localparam int          KW     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [10:0] SCR_W11 = 11'(SCR_W);
  localparam logic [10:0] SCR_H11 = 11'(SCR_H);
  localparam logic [10:0] SPR_W11 = 11'(SPR_W);
  localparam logic [10:0] SPR_H11 = 11'(SPR_H);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;

  logic          slot_en  [NUM_SLOTS];
  logic [3:0]    slot_sel [NUM_SLOTS];
  logic [1:0]    slot_dir [NUM_SLOTS];
  logic [9:0]    slot_x   [NUM_SLOTS];
  logic [9:0]    slot_y   [NUM_SLOTS];

  logic [9:0]    px_q, py_q;
  logic          oob_q;
  logic          rd_pend_q;
  logic          won_q;
  logic [17:0]   result_q;

  logic [10:0]   sx, sy, px11, py11;
  logic          hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_en[i]  <= 1'b0;
        slot_sel[i] <= '0;
        slot_dir[i] <= '0;
        slot_x[i]   <= '0;
        slot_y[i]   <= '0;
      end
    end else if (cfg_we) begin
      slot_en[cfg_slot]  <= cfg_en;
      slot_sel[cfg_slot] <= cfg_sel;
      slot_dir[cfg_slot] <= cfg_dir;
      slot_x[cfg_slot]   <= cfg_x;
      slot_y[cfg_slot]   <= cfg_y;
    end
  end

  // Hit test is done in 11 bits so sx+SPR_W never wraps near the screen edge.
  always_comb begin
    px11 = {1'b0, px_q};
    py11 = {1'b0, py_q};
    sx   = {1'b0, slot_x[k_q]};
    sy   = {1'b0, slot_y[k_q]};
    hit  = (state_q == SCAN) && !oob_q && slot_en[k_q] &&
           (px11 >= sx) && (px11 < sx + SPR_W11) &&
           (py11 >= sy) && (py11 < sy + SPR_H11);
  end

  assign rd_en  = hit;
  assign rd_sel = hit ? slot_sel[k_q] : '0;
  assign rd_dir = hit ? slot_dir[k_q] : '0;
  assign rd_x   = hit ? (px_q - slot_x[k_q]) : '0;
  assign rd_y   = hit ? (py_q - slot_y[k_q]) : '0;

  assign req_ready = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_pixel = result_q;
  assign bg_x      = px_q;
  assign bg_y      = py_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = SCAN;
          k_d     = '0;
        end
      end
      SCAN: begin
        if (k_q == KW'(NUM_SLOTS - 1)) state_d = FLUSH;
        else                           k_d     = k_q + KW'(1);
      end
      FLUSH: state_d = DONE;
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Background arrives at scan step 1, together with slot 0's read return;
  // an opaque sprite return takes precedence over it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_q      <= '0;
      py_q      <= '0;
      oob_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      won_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      rd_pend_q <= hit;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            px_q  <= req_x;
            py_q  <= req_y;
            oob_q <= ({1'b0, req_x} >= SCR_W11) || ({1'b0, req_y} >= SCR_H11);
            won_q <= 1'b0;
          end
        end
        SCAN, FLUSH: begin
          if (rd_pend_q && (rd_data != TRANSP) && !won_q) begin
            result_q <= rd_data;
            won_q    <= 1'b1;
          end else if ((state_q == SCAN) && (k_q == KW'(1))) begin
            result_q <= oob_q ? '0 : bg_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
